// File: rtl/mv_pkg.sv
// rtl/mv_pkg.sv - shared types and helpers for the matrix-vector sequencer
package mv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_e;

    localparam int DRAIN_W = 3;

    function automatic int clog2_min1(input int x);
        return (x <= 2) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/mv_wrap_cnt.sv
// rtl/mv_wrap_cnt.sv - modulo-MAX counter with clear, enable and terminal flag
module mv_wrap_cnt #(
    parameter int MAX = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         at_max_o
);

    generate
        if (MAX <= 1) begin : g_const
            // A single-value counter never moves, so it is always at its terminal count.
            logic inputs_unused;
            assign inputs_unused = clk ^ rst ^ clr_i ^ en_i;
            assign cnt_o         = '0;
            assign at_max_o      = 1'b1;
        end else begin : g_cnt
            logic [W-1:0] cnt_q;
            logic [W-1:0] cnt_d;

            assign at_max_o = (cnt_q == W'(MAX - 1));
            assign cnt_o    = cnt_q;

            always_comb begin
                cnt_d = cnt_q;
                if (clr_i) begin
                    cnt_d = '0;
                end else if (en_i) begin
                    cnt_d = at_max_o ? '0 : cnt_q + W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mv_sched.sv
// rtl/mv_sched.sv - row-by-row dot-product sequencer for the shared MAC datapath
module mv_sched
    import mv_pkg::*;
#(
    parameter int N       = 4,
    parameter int M       = 4,
    parameter int MAC_LAT = 1,
    localparam int AW_M   = clog2_min1(M * N),
    localparam int AW_V   = clog2_min1(N),
    localparam int AW_R   = clog2_min1(M)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [AW_M-1:0] mat_rd_addr,
    output logic [AW_V-1:0] vec_rd_addr,
    output logic            init,
    output logic            mem_wr_en,
    output logic [AW_R-1:0] wr_addr
);

    state_e state_q;
    state_e state_d;

    logic [AW_M-1:0] mat_addr_q;
    logic [AW_M-1:0] mat_addr_d;
    logic [AW_V-1:0] col_cnt;
    logic [AW_R-1:0] row_cnt;
    logic            col_at_max;
    logic            row_at_max;
    logic            drain_at_max;
    logic            to_idle;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (col_at_max) state_d = (MAC_LAT > 0) ? S_DRAIN : S_WRITE;
            S_DRAIN: if (drain_at_max) state_d = S_WRITE;
            S_WRITE: state_d = row_at_max ? S_DONE : S_RUN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort outranks every other transition; it is a no-op when already idle.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    assign to_idle = (state_q != S_IDLE) && (state_d == S_IDLE);

    always_comb begin
        mat_addr_d = mat_addr_q;
        if (to_idle) begin
            mat_addr_d = '0;
        end else if (state_q == S_RUN) begin
            mat_addr_d = mat_addr_q + AW_M'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            mat_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            mat_addr_q <= mat_addr_d;
        end
    end

    mv_wrap_cnt #(.MAX(N), .W(AW_V)) u_col (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (to_idle),
        .en_i     (state_q == S_RUN),
        .cnt_o    (col_cnt),
        .at_max_o (col_at_max)
    );

    mv_wrap_cnt #(.MAX(M), .W(AW_R)) u_row (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (to_idle),
        .en_i     (state_q == S_WRITE),
        .cnt_o    (row_cnt),
        .at_max_o (row_at_max)
    );

    generate
        if (MAC_LAT > 0) begin : g_drain
            logic [DRAIN_W-1:0] drain_cnt_unused;
            mv_wrap_cnt #(.MAX(MAC_LAT), .W(DRAIN_W)) u_drain (
                .clk      (clk),
                .rst      (rst),
                .clr_i    (to_idle),
                .en_i     (state_q == S_DRAIN),
                .cnt_o    (drain_cnt_unused),
                .at_max_o (drain_at_max)
            );
        end else begin : g_no_drain
            assign drain_at_max = 1'b1;
        end
    endgenerate

    // All outputs decode registered state only, so start/abort never reach them combinationally.
    assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_WRITE);
    assign done        = (state_q == S_DONE);
    assign rd_en       = (state_q == S_RUN);
    assign init        = (state_q == S_RUN) && (col_cnt == '0);
    assign mem_wr_en   = (state_q == S_WRITE);
    assign mat_rd_addr = mat_addr_q;
    assign vec_rd_addr = col_cnt;
    assign wr_addr     = row_cnt;

endmodule

// File: tb/tb_mv_sched.sv
// tb/tb_mv_sched.sv - directed self-checking bench for mv_sched
module tb_mv_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, abort_a, start_b, abort_b;

    logic       busy_a, done_a, rd_en_a, init_a, wr_en_a;
    logic [2:0] mat_a;
    logic [1:0] vec_a;
    logic [0:0] wr_a;

    logic       busy_b, done_b, rd_en_b, init_b, wr_en_b;
    logic [1:0] mat_b;
    logic [1:0] vec_b;
    logic [0:0] wr_b;

    logic [7:0] obs_a, obs_b;
    assign obs_a = {busy_a, done_a, rd_en_a, init_a, wr_en_a, vec_a, wr_a};
    assign obs_b = {busy_b, done_b, rd_en_b, init_b, wr_en_b, vec_b, wr_b};

    int n_checks = 0;
    int n_errors = 0;

    mv_sched #(.N(4), .M(2), .MAC_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .rd_en(rd_en_a), .mat_rd_addr(mat_a),
        .vec_rd_addr(vec_a), .init(init_a), .mem_wr_en(wr_en_a), .wr_addr(wr_a)
    );

    mv_sched #(.N(4), .M(1), .MAC_LAT(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .mat_rd_addr(mat_b),
        .vec_rd_addr(vec_b), .init(init_b), .mem_wr_en(wr_en_b), .wr_addr(wr_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {busy,done,rd_en,init,mem_wr_en,vec[1:0],wr[0]} at cycle c of a run.
    function automatic logic [7:0] exp_vec(input int n, input int m, input int l, input int c);
        int p, r, k;
        logic [7:0] v;
        v = '0;
        p = n + l + 1;
        if (c >= 1 && c <= m * p) begin
            r    = (c - 1) / p;
            k    = (c - 1) % p;
            v[7] = 1'b1;
            v[5] = (k < n);
            v[4] = (k == 0);
            v[3] = (k == p - 1);
            v[2:1] = (k < n) ? k[1:0] : 2'd0;
            v[0] = r[0];
        end else if (c == m * p + 1) begin
            v[6] = 1'b1;
        end
        return v;
    endfunction

    task automatic check_a(input string tag, input int c, input bit zero);
        logic [7:0] e;
        e = zero ? 8'h00 : exp_vec(4, 2, 1, c);
        chk(tag, obs_a, e);
        if (e[5]) chk({tag, " mat"}, mat_a, ((c - 1) / 6) * 4 + (c - 1) % 6);
        else if (e == 8'h00) chk({tag, " mat"}, mat_a, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    task automatic run_a(input string name, input int ncyc, input int abort_at);
        pulse_start_a();
        for (int c = 1; c <= ncyc; c++) begin
            if (c == abort_at) abort_a = 1'b1;
            @(negedge clk);
            check_a($sformatf("%s c%0d", name, c), c, (abort_at > 0) && (c > abort_at));
            step();
            abort_a = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
        step();
        @(negedge clk);
        check_a("reset a", 0, 1'b1);
        chk("reset b", obs_b, 0);
        chk("reset b mat", mat_b, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            abort_a = 1'b1;
            @(negedge clk);
            check_a($sformatf("idle abort %0d", i), 0, 1'b1);
            step();
        end
        abort_a = 1'b0;

        run_a("basic", 14, 0);

        @(negedge clk);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk($sformatf("lat0 c%0d", c), obs_b, exp_vec(4, 1, 0, c));
            if (c <= 4) chk($sformatf("lat0 c%0d mat", c), mat_b, c - 1);
            step();
        end

        @(negedge clk);
        start_a = 1'b1;
        step();
        for (int g = 1; g <= 28; g++) begin
            if (g == 15) start_a = 1'b0;
            @(negedge clk);
            if (g <= 13)       check_a($sformatf("hold c%0d", g), g, 1'b0);
            else if (g == 14)  check_a($sformatf("hold c%0d", g), 0, 1'b1);
            else               check_a($sformatf("hold c%0d", g), g - 14, 1'b0);
            step();
        end

        run_a("abort3", 14, 3);
        run_a("after_abort", 14, 0);
        run_a("abort_wr", 15, 6);

        pulse_start_a();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check_a($sformatf("prerst c%0d", c), c, 1'b0);
            step();
        end
        chk("drain busy", busy_a, 1);
        chk("drain rd_en", rd_en_a, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst outs", obs_a, 0);
        chk("async rst mat", mat_a, 0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_a($sformatf("post rst idle %0d", i), 0, 1'b1);
            step();
        end
        run_a("post_rst", 14, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
